// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB command path: FSM encoding,
// end-of-table marker, sensor ID and default timing.
package sccb_pkg;

  typedef enum logic [7:0] {
    PWR_WAIT  = 8'h00,
    FETCH     = 8'h01,
    CHECK     = 8'h02,
    ISSUE     = 8'h03,
    WAIT_DONE = 8'h04,
    GAP       = 8'h05,
    READY     = 8'h06
  } state_t;

  localparam logic [15:0] SCCB_END_MARKER = 16'hFFFF;
  localparam logic [7:0]  SCCB_ID_ADDR    = 8'h42;

  localparam int SCCB_CNT_W        = 20;
  localparam int SCCB_INIT_LEN     = 37;
  localparam int SCCB_PWR_WAIT_CYC = 25000;
  localparam int SCCB_GAP_CYC      = 2500;

  // Terminal count for a wait of `cyc` cycles (count runs 0..cyc-1).
  function automatic logic [SCCB_CNT_W-1:0] sccb_term_cnt(input int cyc);
    return SCCB_CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/sccb_cmd_sched_if.sv
// Host-write and engine-command handshakes around the SCCB scheduler.
interface sccb_cmd_sched_if;
  logic        host_valid;
  logic [15:0] host_data;
  logic        host_ready;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        cmd_done;

  modport master (
    input  host_valid, host_data, cmd_ready, cmd_done,
    output host_ready, cmd_valid, cmd_data
  );

  modport slave (
    output host_valid, host_data, cmd_ready, cmd_done,
    input  host_ready, cmd_valid, cmd_data
  );
endinterface

// File: rtl/sccb_gap_timer.sv
// Load/count/expire counter shared by the power-on wait and the
// inter-command gap; saturates at its terminal count.
module sccb_gap_timer #(
  parameter int W = 20
) (
  input  logic         clk_25m,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (en && (cnt_q != limit) && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == limit);

endmodule

// File: rtl/sccb_cmd_sched.sv
// Sole issuer of SCCB engine commands: power-on wait, init-table walk,
// then host register writes, with a fixed idle gap after every command.
module sccb_cmd_sched
  import sccb_pkg::*;
#(
  parameter int INIT_LEN     = SCCB_INIT_LEN,
  parameter int PWR_WAIT_CYC = SCCB_PWR_WAIT_CYC,
  parameter int GAP_CYC      = SCCB_GAP_CYC
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              restart,
  output logic [7:0]        addr_rom,
  input  logic [15:0]       sreg,
  sccb_cmd_sched_if.master  bus,
  output logic              init_done,
  output logic              busy
);

  if (INIT_LEN < 1 || INIT_LEN > 255) begin : g_bad_init_len
    $error("INIT_LEN must be in 1..255");
  end
  if (PWR_WAIT_CYC < 1 || PWR_WAIT_CYC >= (1 << SCCB_CNT_W)) begin : g_bad_pwr_wait
    $error("PWR_WAIT_CYC must be in 1..2^20-1");
  end
  if (GAP_CYC < 1 || GAP_CYC >= (1 << SCCB_CNT_W)) begin : g_bad_gap
    $error("GAP_CYC must be in 1..2^20-1");
  end

  localparam logic [7:0]            LAST_IDX = 8'(INIT_LEN);
  localparam logic [SCCB_CNT_W-1:0] PWR_LIM  = sccb_term_cnt(PWR_WAIT_CYC);
  localparam logic [SCCB_CNT_W-1:0] GAP_LIM  = sccb_term_cnt(GAP_CYC);

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic        src_host_q, src_host_d;
  logic        init_done_q, init_done_d;
  logic        pend_q, pend_d;
  logic        restart_pend;
  logic        tmr_load, tmr_en, tmr_exp;
  logic [SCCB_CNT_W-1:0] tmr_limit;

  sccb_gap_timer #(.W(SCCB_CNT_W)) u_timer (
    .clk_25m (clk_25m),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .expire  (tmr_exp)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmd_data_d   = cmd_data_q;
    src_host_d   = src_host_q;
    init_done_d  = init_done_q;
    // A restart arriving this cycle already blocks a host handshake.
    restart_pend = pend_q | restart;

    case (state_q)
      PWR_WAIT:  if (!restart && tmr_exp) state_d = FETCH;
      FETCH:     state_d = CHECK;
      CHECK: begin
        if (sreg == SCCB_END_MARKER) begin
          init_done_d = 1'b1;
          state_d     = READY;
        end else begin
          cmd_data_d = sreg;
          src_host_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE:     if (bus.cmd_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.cmd_done) begin
          state_d = GAP;
          if (!src_host_q) addr_d = addr_q + 8'd1;
        end
      end
      GAP: begin
        if (tmr_exp) begin
          if (restart_pend)
            state_d = PWR_WAIT;
          else if (!src_host_q && (addr_q != LAST_IDX))
            state_d = FETCH;
          else begin
            state_d = READY;
            if (!src_host_q) init_done_d = 1'b1;
          end
        end
      end
      READY: begin
        if (restart_pend)
          state_d = PWR_WAIT;
        else if (bus.host_valid) begin
          cmd_data_d = bus.host_data;
          src_host_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      default:   state_d = PWR_WAIT;
    endcase

    if (state_d == PWR_WAIT) begin
      addr_d      = 8'd0;
      init_done_d = 1'b0;
    end
    pend_d = restart_pend && (state_d != PWR_WAIT);

    // Every state change starts the timer from zero; restart re-arms the power-on wait.
    tmr_load  = (state_d != state_q) || ((state_q == PWR_WAIT) && restart);
    tmr_en    = (state_q == PWR_WAIT) || (state_q == GAP);
    tmr_limit = (state_q == PWR_WAIT) ? PWR_LIM : GAP_LIM;
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      addr_q      <= 8'd0;
      cmd_data_q  <= 16'd0;
      src_host_q  <= 1'b0;
      init_done_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_data_q  <= cmd_data_d;
      src_host_q  <= src_host_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
    end
  end

  assign addr_rom       = addr_q;
  assign init_done      = init_done_q;
  assign busy           = (state_q != READY);
  assign bus.cmd_valid  = (state_q == ISSUE);
  assign bus.cmd_data   = cmd_data_q;
  assign bus.host_ready = (state_q == READY) && !restart_pend;

endmodule

// File: tb/tb_sccb_cmd_sched.sv
// Directed bench for sccb_cmd_sched: small timing parameters, a synchronous
// ROM model and an engine that pulses cmd_done a fixed delay after acceptance.
module tb_sccb_cmd_sched;
  import sccb_pkg::*;

  localparam int P = 20;
  localparam int G = 8;
  localparam int L = 3;
  localparam int D = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  addr_rom;
  logic [15:0] sreg;
  logic        init_done;
  logic        busy;
  logic [15:0] rom [0:7];

  logic        eng_done = 1'b0;
  logic        acc_evt = 1'b0;
  int          dcnt = 0;
  int          acc_cnt = 0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          base;
  int          stable;

  sccb_cmd_sched_if bus();
  assign bus.cmd_done = eng_done;

  always #5 clk = ~clk;

  sccb_cmd_sched #(.INIT_LEN(L), .PWR_WAIT_CYC(P), .GAP_CYC(G)) dut (
    .clk_25m   (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .addr_rom  (addr_rom),
    .sreg      (sreg),
    .bus       (bus),
    .init_done (init_done),
    .busy      (busy)
  );

  always @(posedge clk) sreg <= rom[addr_rom[2:0]];

  always @(posedge clk) begin
    acc_evt <= rst_n && bus.cmd_valid && bus.cmd_ready;
    if (rst_n && bus.cmd_valid && bus.cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  // cmd_done is sampled by the DUT D posedges after the accepting posedge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt     = 0;
      eng_done = 1'b0;
    end else begin
      eng_done = 1'b0;
      if (dcnt != 0) begin
        dcnt = dcnt - 1;
        if (dcnt == 0) eng_done = 1'b1;
      end
      if (acc_evt) dcnt = D - 1;
    end
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic go(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_rom(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
    for (int i = 3; i < 8; i++) rom[i] = SCCB_END_MARKER;
  endtask

  task automatic reset_release();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid",  16'(bus.cmd_valid),  16'd0);
    chk("rst_cmd_data",   bus.cmd_data,        16'd0);
    chk("rst_host_ready", 16'(bus.host_ready), 16'd0);
    chk("rst_init_done",  16'(init_done),      16'd0);
    chk("rst_busy",       16'(busy),           16'd1);
    chk("rst_addr_rom",   16'(addr_rom),       16'd0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    bus.host_valid = 1'b0;
    bus.host_data  = 16'd0;
    bus.cmd_ready  = 1'b1;

    // Power-on walk of a three-entry table
    set_rom(16'h1201, 16'h3a04, 16'h4080);
    reset_release();
    go(P + 1); chk("pwr_no_early_valid", 16'(bus.cmd_valid), 16'd0);
    go(P + 2); chk("pwr_first_valid",    16'(bus.cmd_valid), 16'd1);
               chk("pwr_rom0_data",      bus.cmd_data,       16'h1201);
    go(P + 3); chk("pwr_valid_drops",    16'(bus.cmd_valid), 16'd0);
               chk("pwr_busy",           16'(busy),          16'd1);
    go(42);    chk("gap1_no_early",      16'(bus.cmd_valid), 16'd0);
    go(43);    chk("gap1_valid",         16'(bus.cmd_valid), 16'd1);
               chk("gap1_rom1_data",     bus.cmd_data,       16'h3a04);
    go(63);    chk("gap2_no_early",      16'(bus.cmd_valid), 16'd0);
    go(64);    chk("gap2_valid",         16'(bus.cmd_valid), 16'd1);
               chk("gap2_rom2_data",     bus.cmd_data,       16'h4080);
    go(82);    chk("init_not_yet",       16'(init_done),     16'd0);
    go(83);    chk("init_done_set",      16'(init_done),     16'd1);
               chk("ready_not_busy",     16'(busy),          16'd0);
               chk("ready_addr",         16'(addr_rom),      16'd3);
               chk("ready_host_ready",   16'(bus.host_ready), 16'd1);

    // End marker in the second entry
    set_rom(16'h1201, SCCB_END_MARKER, 16'h4080);
    reset_release();
    base = acc_cnt;
    go(P + 2); chk("end_rom0_data",      bus.cmd_data,       16'h1201);
    go(42);    chk("end_check_cycle",    16'(init_done),     16'd0);
    go(43);    chk("end_init_done",      16'(init_done),     16'd1);
               chk("end_not_busy",       16'(busy),          16'd0);
               chk("end_addr_stays",     16'(addr_rom),      16'd1);
    go(60);    chk("end_no_valid",       16'(bus.cmd_valid), 16'd0);
               chk("end_one_cmd",        16'(acc_cnt - base), 16'd1);

    // Host request held from reset waits for init to finish
    set_rom(16'h1201, 16'h3a04, 16'h4080);
    bus.host_valid = 1'b1;
    bus.host_data  = 16'h1340;
    reset_release();
    go(10);    chk("host_blk_pwr",       16'(bus.host_ready), 16'd0);
    go(43);    chk("host_blk_issue",     16'(bus.host_ready), 16'd0);
    go(82);    chk("host_blk_gap",       16'(bus.host_ready), 16'd0);
    go(83);    chk("host_ready_up",      16'(bus.host_ready), 16'd1);
               chk("host_no_valid_yet",  16'(bus.cmd_valid),  16'd0);
    go(84);    chk("host_cmd_valid",     16'(bus.cmd_valid),  16'd1);
               chk("host_cmd_data",      bus.cmd_data,        16'h1340);
               chk("host_ready_drops",   16'(bus.host_ready), 16'd0);
    bus.host_valid = 1'b0;
    go(103);   chk("host_back_ready",    16'(bus.host_ready), 16'd1);
               chk("host_init_kept",     16'(init_done),      16'd1);

    // Backpressure: engine refuses for 50 ISSUE cycles
    bus.cmd_ready  = 1'b0;
    bus.host_valid = 1'b1;
    bus.host_data  = 16'h1002;
    base = acc_cnt;
    go(104);
    bus.host_valid = 1'b0;
    stable = 0;
    while (cyc <= 153) begin
      if (bus.cmd_valid === 1'b1 && bus.cmd_data === 16'h1002) stable++;
      step();
    end
    chk("bp_stable_cycles",  16'(stable),          16'd50);
    chk("bp_still_valid",    16'(bus.cmd_valid),   16'd1);
    chk("bp_no_accept",      16'(acc_cnt - base),  16'd0);
    bus.cmd_ready = 1'b1;
    go(155);   chk("bp_accepted",        16'(bus.cmd_valid),  16'd0);
               chk("bp_one_accept",      16'(acc_cnt - base), 16'd1);
    go(173);   chk("bp_back_ready",      16'(bus.host_ready), 16'd1);

    // Restart pulsed while the first init command is outstanding
    reset_release();
    go(25);
    restart = 1'b1;
    step();
    restart = 1'b0;
    go(40);    chk("rst_gap_addr",       16'(addr_rom),       16'd1);
               chk("rst_gap_busy",       16'(busy),           16'd1);
    go(41);    chk("rst_pwr_addr",       16'(addr_rom),       16'd0);
               chk("rst_pwr_init",       16'(init_done),      16'd0);
               chk("rst_pwr_valid",      16'(bus.cmd_valid),  16'd0);
    go(62);    chk("replay_no_early",    16'(bus.cmd_valid),  16'd0);
    go(63);    chk("replay_rom0",        bus.cmd_data,        16'h1201);
               chk("replay_valid0",      16'(bus.cmd_valid),  16'd1);
    go(84);    chk("replay_rom1",        bus.cmd_data,        16'h3a04);
    go(105);   chk("replay_rom2",        bus.cmd_data,        16'h4080);
    go(123);   chk("replay_init_low",    16'(init_done),      16'd0);
    go(124);   chk("replay_init_done",   16'(init_done),      16'd1);

    // Asynchronous reset while a host command is stalled in ISSUE
    bus.cmd_ready  = 1'b0;
    bus.host_valid = 1'b1;
    bus.host_data  = 16'h2211;
    go(125);   chk("areset_issue",       bus.cmd_data,        16'h2211);
    bus.host_valid = 1'b0;
    go(127);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid",     16'(bus.cmd_valid), 16'd0);
    chk("areset_busy",      16'(busy),          16'd1);
    chk("areset_init_done", 16'(init_done),     16'd0);
    bus.cmd_ready = 1'b1;
    reset_release();
    go(P + 1); chk("areset_no_early",    16'(bus.cmd_valid),  16'd0);
    go(P + 2); chk("areset_first_valid", 16'(bus.cmd_valid),  16'd1);
               chk("areset_rom0",        bus.cmd_data,        16'h1201);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sccb_cmd_sched.md
# sccb_cmd_sched

Command scheduler in front of the SCCB write engine. After a power-on wait it walks the camera init table (the register ROM), then shares the engine between the init sequence and runtime host register writes (exposure/gain updates). It enforces a minimum inter-command gap and reports init completion. It is the only block that issues commands to the engine.

## Interface
Parameters:
- INIT_LEN, 37: number of ROM entries in the init table (indices 0..INIT_LEN-1).
- PWR_WAIT_CYC, 25000: clk_25m cycles from reset release to the first command (1 ms).
- GAP_CYC, 2500: idle cycles after each cmd_done before the next issue (100 µs).

Ports:
- clk_25m  in  1  sole clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  single-cycle pulse that re-runs the init table.
- addr_rom  out  8  ROM index.
- sreg  in  16  ROM data {reg_addr, reg_val}, valid 1 cycle after addr_rom.
- host_valid  in  1  host write request.
- host_data  in  16  host {reg_addr, reg_val}.
- host_ready  out  1  host handshake accept.
- cmd_valid  out  1  command to engine.
- cmd_data  out  16  command payload.
- cmd_ready  in  1  engine accepts when cmd_valid && cmd_ready.
- cmd_done  in  1  one-cycle pulse when the bus transfer completes.
- init_done  out  1  init table fully sent.
- busy  out  1  high in every state except READY.

## Operation
- States: PWR_WAIT, FETCH, CHECK, ISSUE, WAIT_DONE, GAP, READY.
- Reset values: state=PWR_WAIT, wait counter=0, addr_rom=0, cmd_valid=0, cmd_data=0, host_ready=0, init_done=0, busy=1. The init/host source flag resets to init.
- **PWR_WAIT:** count to PWR_WAIT_CYC-1, then go to FETCH.
- **FETCH:** addr_rom is stable for this cycle. Go to CHECK.
- **CHECK:** sample sreg.
  - If sreg==16'hFFFF (end marker), set init_done=1 and go to READY.
  - Otherwise latch cmd_data=sreg, source=init, and go to ISSUE.
- **ISSUE:** hold cmd_valid=1 with cmd_data stable until cmd_ready. On acceptance go to WAIT_DONE, with cmd_valid=0 from the next cycle.
- **WAIT_DONE:** wait for cmd_done, then go to GAP.
  - If source=init, increment addr_rom.
  - If the new index equals INIT_LEN, set init_done=1 on GAP exit.
- **GAP:** count GAP_CYC cycles, then branch in this order:
  - restart pending: go to PWR_WAIT.
  - source=init and !init_done: go to FETCH.
  - otherwise: go to READY.
- **READY:** host_ready=1 (combinational: state==READY && !restart_pend).
  - Handshake when host_valid && host_ready: latch cmd_data=host_data, source=host, and go to ISSUE.
  - While host_valid is low, stay in READY.
- **restart:**
  - Sets restart_pend. restart_pend is cleared on entry to PWR_WAIT; PWR_WAIT, addr_rom and init_done are all reset there.
  - In READY, restart_pend takes effect next cycle. A simultaneous host_valid is refused because host_ready is already low that cycle.
  - In ISSUE, WAIT_DONE or GAP, the current command always completes its handshake and gap first. No command is ever abandoned after acceptance.
  - During PWR_WAIT, restart restarts the count.
- A cmd_done arriving outside WAIT_DONE is ignored.
- Asynchronous reset mid-transfer returns to PWR_WAIT. The engine is reset by the same rst_n.

## Timing
- addr_rom to sreg: 1 cycle (synchronous ROM). CHECK samples exactly 1 cycle after FETCH.
- Reset release to first cmd_valid: PWR_WAIT_CYC + 2 cycles.
- cmd_done to next init cmd_valid: GAP_CYC + 2 cycles (GAP, FETCH, CHECK).
- Host handshake to cmd_valid: 1 cycle.
- init_done rises on the cycle that leaves GAP (or CHECK for the end marker). It stays high until a restart reaches PWR_WAIT or rst_n asserts.
- Counters:
  - Wait counter is 20 bits, saturating and unsigned. Parameters must be < 2^20, checked by a static assertion.
  - addr_rom is 8 bits. INIT_LEN ≤ 255 is asserted, so no wraparound.

## Structure
- Package sccb_pkg holds:
  - the state_t enum (8-bit encoding, consistent with existing SCCB code);
  - SCCB_END_MARKER=16'hFFFF;
  - SCCB_ID_ADDR=8'h42;
  - the default timing constants.
- Sub-module sccb_gap_timer: load/count/expire counter, shared by PWR_WAIT and GAP.
- The rest is a single FSM plus datapath registers, about 200 lines.

## Test plan
- **Power-on:** reset release with INIT_LEN=3, cmd_ready=1 and cmd_done 10 cycles after acceptance.
  - First cmd_valid at cycle PWR_WAIT_CYC+2 with cmd_data=ROM[0].
  - ROM[1] and ROM[2] follow with exact GAP spacing.
  - init_done=1 after the third gap.
- **End marker:** ROM[1]=16'hFFFF.
  - Only ROM[0] is issued.
  - init_done=1 in the cycle after CHECK.
  - addr_rom stays 1.
- **Host arbitration:** host_valid=1, host_data=16'h1340 held from reset.
  - host_ready stays 0 during init.
  - After init_done, a one-cycle handshake occurs and cmd_data=16'h1340 on the next cycle.
- **Backpressure:** cmd_ready low for 50 cycles.
  - cmd_valid and cmd_data stay stable.
  - No second command is issued.
  - Acceptance happens on the first cycle cmd_ready=1.
- **Restart mid-command:** pulse restart in WAIT_DONE.
  - The command completes and its gap runs.
  - Then PWR_WAIT, addr_rom=0, init_done=0, and the full table is replayed.
- **Async reset during ISSUE:** assert rst_n=0 mid-command.
  - cmd_valid=0, busy=1 and init_done=0 immediately.
  - On release, the power-on sequence repeats.
